aes_state_regs_shared: RTL and testbench
========================================

Name: aes_state_regs_shared

Overview:
- Byte-serial AES state register, generalised to SHARES-way Boolean masking for threshold-implementation datapaths. Supports both encryption and decryption.
- Holds a 4x4 byte state per share, organised as a 16-stage column-major shift chain. Applies ShiftRows/InvShiftRows and MixColumns/InvMixColumns per share.
- Sits between the shared S-box output and the key-add/S-box input of the round datapath.
- New features:
  - hold enable
  - synchronous clear
  - byte-position counter with a column-alignment check

Parameters:
- SHARES, 3, number of Boolean shares (1..4); the datapath width is 8*SHARES.

Ports:
- ClkxCI  in  1  clock
- RstxBI  in  1  reset, asynchronous, active-low
- EnxSI  in  1  advance enable; 0 = all state, counter and flags hold
- ClearxSI  in  1  synchronous clear of array, counter and error flag
- InvxSI  in  1  0 = encrypt ops, 1 = inverse ops
- ShiftRowsxSI  in  1  apply (Inv)ShiftRows permutation this cycle
- MixColumnsxSI  in  1  apply (Inv)MixColumns to head column this cycle
- StateInxDI  in  8*SHARES  shared byte in; share s = bits [8s+7:8s]
- StateOutxDO  out  8*SHARES  shared byte out (combinational)
- BytePtrxDO  out  4  number of shift cycles mod 16
- ColStartxSO  out  1  BytePtr[1:0]==0 (head holds a fresh column)
- MixErrxSO  out  1  sticky: MixColumns requested off column boundary

Behaviour:
- Per share s: registers Sij (row i, column j), each 8 bits.
- Chain positions: Pk = S(k mod 4)(k div 4), for k=0..15. P0 is the head, P15 the tail.
- Column-major stream order: byte k lands at row k mod 4, column k div 4.
- Reset (async, RstxBI=0), and also on ClearxSI=1 (synchronous, only when EnxSI=1):
  - all Sij=0, BytePtr=0, MixErrxSO=0.
  - Resulting outputs: StateOutxDO=0, ColStartxSO=1.
- Priority when EnxSI=1: ClearxSI > ShiftRowsxSI > MixColumnsxSI > normal.
- Normal shift:
  - Pk<=Pk+1 for k<15; P15<=StateInxDI.
  - StateOutxDO=P0. BytePtr<=BytePtr+1, wrapping 15->0.
- ShiftRows cycle (no shift, input ignored, BytePtr unchanged):
  - InvxSI=0: Sij<=Si((j+i) mod 4).
  - InvxSI=1: Sij<=Si((j-i) mod 4).
  - StateOutxDO=P0 (pre-permutation). The controller must not consume it.
- MixColumns cycle, legal only when ColStartxSO=1:
  - Compute column (b0..b3) = (P0..P3) per share. Matrix per InvxSI:
    - InvxSI=0: circ(02,03,01,01).
    - InvxSI=1: circ(0e,0b,0d,09).
  - Arithmetic in GF(2^8), reduction polynomial 0x11b.
  - Write-back: StateOutxDO=b0; P0<=b1, P1<=b2, P2<=b3; P3..P14<=P4..P15; P15<=StateInxDI.
  - BytePtr increments.
  - MixColumns is linear, so it is applied per share with no cross-share terms. The XOR of share outputs equals the unmasked result.
- MixColumnsxSI with ColStartxSO=0:
  - Request ignored; a normal shift is performed.
  - MixErrxSO<=1 (sticky until reset or clear).
- ShiftRowsxSI and MixColumnsxSI both high: ShiftRows only. No error is flagged.
- EnxSI=0: all registers, BytePtr and MixErrxSO hold. StateOutxDO still reflects the current P0 (or the MixColumns b0 if MixColumnsxSI=1 and ColStartxSO=1).
- Latency: a byte written at cycle t appears on StateOutxDO after 15 further enabled shift cycles.
- Reset asserted mid-operation clears immediately. There is no partial-state retention.

Test Plan:
- Encrypt ShiftRows (SHARES=1):
  - Stimulus: stream 00..0f, then assert ShiftRowsxSI, then 16 normal shifts with in=ff.
  - Required out stream: 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. BytePtr=0 after stream and after the 16 shifts.
- Inverse ShiftRows (InvxSI=1):
  - Stimulus: stream the previous output sequence, assert ShiftRowsxSI.
  - Required out stream: 00..0f.
- MixColumns (SHARES=1, FIPS-197 column):
  - Stimulus: load db 13 53 45 into P0..P3, then MixColumnsxSI at BytePtr=0.
  - Required: out/next bytes 8e 4d a1 bc.
  - Same with InvxSI=1 on input 8e 4d a1 bc: required result db 13 53 45.
- Masked MixColumns (SHARES=3):
  - Stimulus: share0=db^m0^m1 (per byte), share1=m0, share2=m1, with random m0/m1 per byte.
  - Required: XOR of the three output shares = 8e 4d a1 bc for 100 random masks.
- Misalignment:
  - Stimulus: MixColumnsxSI at BytePtr=1.
  - Required: normal shift, MixErrxSO=1 and it stays 1. ClearxSI with EnxSI=1 -> MixErrxSO=0, BytePtr=0, out=0.
- Hold and reset:
  - Stimulus: EnxSI=0 for 5 cycles mid-stream.
  - Required: BytePtr and array unchanged; stream resumes intact.
  - Async RstxBI=0 mid-cycle: all outputs 0 and ColStartxSO=1 without waiting for a clock edge.

Source files
------------

// File: rtl/aes_state_regs_shared_if.sv
// Control and data bundle of the shared byte-serial AES state register.
// The master drives the controls and the input byte; the slave returns the state view.
interface aes_state_regs_shared_if #(
  parameter int unsigned SHARES = 3
);
  logic                  EnxSI;
  logic                  ClearxSI;
  logic                  InvxSI;
  logic                  ShiftRowsxSI;
  logic                  MixColumnsxSI;
  logic [8*SHARES-1:0]   StateInxDI;
  logic [8*SHARES-1:0]   StateOutxDO;
  logic [3:0]            BytePtrxDO;
  logic                  ColStartxSO;
  logic                  MixErrxSO;

  modport master (
    output EnxSI, ClearxSI, InvxSI, ShiftRowsxSI, MixColumnsxSI, StateInxDI,
    input  StateOutxDO, BytePtrxDO, ColStartxSO, MixErrxSO
  );

  modport slave (
    input  EnxSI, ClearxSI, InvxSI, ShiftRowsxSI, MixColumnsxSI, StateInxDI,
    output StateOutxDO, BytePtrxDO, ColStartxSO, MixErrxSO
  );
endinterface

// File: rtl/aes_state_regs_shared.sv
// Byte-serial, Boolean-masked AES state: 16-stage column-major chain per share with
// (Inv)ShiftRows and (Inv)MixColumns applied share-wise (both ops are linear).
module aes_state_regs_shared #(
  parameter int unsigned SHARES = 3
) (
  input logic                   ClkxCI,
  input logic                   RstxBI,
  aes_state_regs_shared_if.slave Bus
);

  typedef logic [3:0][7:0] colT;

  logic [SHARES-1:0][15:0][7:0] StatexDP, StatexDN;
  logic [3:0]                   BytePtrxDP, BytePtrxDN;
  logic                         MixErrxSP, MixErrxSN;
  colT  [SHARES-1:0]            MixColxD;
  logic [SHARES-1:0][7:0]       StateOutxD;
  logic                         ColStartxS, DoMixxS;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of both circulant matrices takes coefficient n on column (r+n) mod 4.
  function automatic colT mixCol(input colT a, input logic inv);
    colT res, m1, m2, m3, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    for (int c = 0; c < 4; c++) begin
      x2    = xtime(a[c]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m1[c] = a[c];
      m2[c] = x2;
      m3[c] = x2 ^ a[c];
      m9[c] = x8 ^ a[c];
      mb[c] = x8 ^ x2 ^ a[c];
      md[c] = x8 ^ x4 ^ a[c];
      me[c] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[r] = inv ? (me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4])
                   : (m2[r] ^ m3[(r + 1) % 4] ^ m1[(r + 2) % 4] ^ m1[(r + 3) % 4]);
    end
    return res;
  endfunction

  assign ColStartxS = (BytePtrxDP[1:0] == 2'd0);
  // ShiftRows wins over MixColumns, and an off-boundary MixColumns degrades to a shift.
  assign DoMixxS    = Bus.MixColumnsxSI & ~Bus.ShiftRowsxSI & ColStartxS;

  always_comb begin
    MixColxD   = '0;
    StateOutxD = '0;
    for (int s = 0; s < SHARES; s++) begin
      MixColxD[s]   = mixCol(StatexDP[s][3:0], Bus.InvxSI);
      StateOutxD[s] = DoMixxS ? MixColxD[s][0] : StatexDP[s][0];
    end
  end

  always_comb begin
    StatexDN   = StatexDP;
    BytePtrxDN = BytePtrxDP;
    MixErrxSN  = MixErrxSP;
    if (Bus.EnxSI) begin
      if (Bus.ClearxSI) begin
        StatexDN   = '0;
        BytePtrxDN = '0;
        MixErrxSN  = 1'b0;
      end else if (Bus.ShiftRowsxSI) begin
        // Position of S(i,j) in the chain is i + 4j.
        for (int s = 0; s < SHARES; s++) begin
          for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
              StatexDN[s][i + 4 * j] = Bus.InvxSI ? StatexDP[s][i + 4 * ((j + 4 - i) % 4)]
                                                  : StatexDP[s][i + 4 * ((j + i) % 4)];
            end
          end
        end
      end else begin
        for (int s = 0; s < SHARES; s++) begin
          for (int k = 0; k < 15; k++) begin
            StatexDN[s][k] = StatexDP[s][k + 1];
          end
          StatexDN[s][15] = Bus.StateInxDI[8 * s +: 8];
          if (DoMixxS) begin
            StatexDN[s][0] = MixColxD[s][1];
            StatexDN[s][1] = MixColxD[s][2];
            StatexDN[s][2] = MixColxD[s][3];
          end
        end
        BytePtrxDN = BytePtrxDP + 4'd1;
        if (Bus.MixColumnsxSI && !ColStartxS) begin
          MixErrxSN = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP   <= '0;
      BytePtrxDP <= '0;
      MixErrxSP  <= 1'b0;
    end else begin
      StatexDP   <= StatexDN;
      BytePtrxDP <= BytePtrxDN;
      MixErrxSP  <= MixErrxSN;
    end
  end

  assign Bus.StateOutxDO = StateOutxD;
  assign Bus.BytePtrxDO  = BytePtrxDP;
  assign Bus.ColStartxSO = ColStartxS;
  assign Bus.MixErrxSO   = MixErrxSP;

endmodule

// File: tb/tb_aes_state_regs_shared.sv
// Bench for aes_state_regs_shared: every byte is freshly masked across three shares and
// the unmasked (XOR of shares) output is checked against a queue of expected bytes.
module tb_aes_state_regs_shared;

  localparam int unsigned SH = 3;

  logic ClkxCI = 1'b0;
  logic RstxBI = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  logic [7:0] expQ[$];

  aes_state_regs_shared_if #(.SHARES(SH)) bus ();

  aes_state_regs_shared #(.SHARES(SH)) dut (
    .ClkxCI (ClkxCI),
    .RstxBI (RstxBI),
    .Bus    (bus)
  );

  always #5 ClkxCI = ~ClkxCI;

  function automatic logic [7:0] unmask(input logic [8*SH-1:0] v);
    logic [7:0] acc = '0;
    for (int s = 0; s < SH; s++) acc ^= v[8 * s +: 8];
    return acc;
  endfunction

  // Drive one cycle of controls and a freshly masked byte; o is the unmasked output
  // sampled before the edge.
  task automatic cyc(input logic en, input logic clr, input logic inv, input logic sr,
                     input logic mc, input logic [7:0] b, output logic [7:0] o);
    logic [8*SH-1:0] v;
    logic [7:0]      acc;
    acc = b;
    for (int s = 1; s < SH; s++) begin
      v[8 * s +: 8] = 8'($urandom);
      acc ^= v[8 * s +: 8];
    end
    v[7:0]            = acc;
    bus.EnxSI         = en;
    bus.ClearxSI      = clr;
    bus.InvxSI        = inv;
    bus.ShiftRowsxSI  = sr;
    bus.MixColumnsxSI = mc;
    bus.StateInxDI    = v;
    #1;
    o = unmask(bus.StateOutxDO);
    @(posedge ClkxCI);
    #1;
  endtask

  task automatic shift(input logic [7:0] b, output logic [7:0] o);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b, o);
  endtask

  task automatic clear();
    logic [7:0] o;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, o);
  endtask

  task automatic test_reset();
    logic [7:0] o;
    bus.EnxSI = 1'b0; bus.ClearxSI = 1'b0; bus.InvxSI = 1'b0;
    bus.ShiftRowsxSI = 1'b0; bus.MixColumnsxSI = 1'b0; bus.StateInxDI = '0;
    RstxBI = 1'b0;
    repeat (2) @(posedge ClkxCI);
    #3;
    total += 4;
    if (bus.StateOutxDO !== '0) begin
      bad++; $display("FAIL reset_out: got %h want 0", bus.StateOutxDO);
    end
    if (bus.BytePtrxDO !== 4'd0) begin
      bad++; $display("FAIL reset_ptr: got %0d want 0", bus.BytePtrxDO);
    end
    if (bus.ColStartxSO !== 1'b1) begin
      bad++; $display("FAIL reset_colstart: got %b want 1", bus.ColStartxSO);
    end
    if (bus.MixErrxSO !== 1'b0) begin
      bad++; $display("FAIL reset_err: got %b want 0", bus.MixErrxSO);
    end
    RstxBI = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, o);
  endtask

  task automatic test_shift_rows();
    logic [7:0] o, e;
    logic [7:0] srExp [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                               8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
    clear();
    for (int k = 0; k < 16; k++) shift(8'(k), o);
    total++;
    if (bus.BytePtrxDO !== 4'd0) begin
      bad++; $display("FAIL sr_ptr_load: got %0d want 0", bus.BytePtrxDO);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, o);
    for (int k = 0; k < 16; k++) expQ.push_back(srExp[k]);
    for (int k = 0; k < 16; k++) begin
      shift(8'hff, o);
      e = expQ.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL sr_out[%0d]: got %h want %h", k, o, e);
      end
    end
    total++;
    if (bus.BytePtrxDO !== 4'd0) begin
      bad++; $display("FAIL sr_ptr_after: got %0d want 0", bus.BytePtrxDO);
    end
    // Inverse: feed the permuted stream back and expect identity order.
    for (int k = 0; k < 16; k++) shift(srExp[k], o);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, o);
    for (int k = 0; k < 16; k++) expQ.push_back(8'(k));
    for (int k = 0; k < 16; k++) begin
      shift(8'hff, o);
      e = expQ.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL isr_out[%0d]: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic mix_run(input logic inv, input logic [31:0] col, input logic [31:0] res,
                         input string tag);
    logic [7:0] o, e;
    clear();
    for (int k = 0; k < 4; k++) shift(col[31 - 8 * k -: 8], o);
    for (int k = 4; k < 16; k++) shift(8'($urandom), o);
    for (int k = 0; k < 4; k++) expQ.push_back(res[31 - 8 * k -: 8]);
    cyc(1'b1, 1'b0, inv, 1'b0, 1'b1, 8'($urandom), o);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) shift(8'($urandom), o);
      e = expQ.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL %s[%0d]: got %h want %h", tag, k, o, e);
      end
    end
    total++;
    if (bus.MixErrxSO !== 1'b0) begin
      bad++; $display("FAIL %s_err: got %b want 0", tag, bus.MixErrxSO);
    end
  endtask

  task automatic test_mix_columns();
    mix_run(1'b0, 32'hdb135345, 32'h8e4da1bc, "mc");
    mix_run(1'b1, 32'h8e4da1bc, 32'hdb135345, "imc");
  endtask

  task automatic test_masked_mix();
    for (int n = 0; n < 100; n++) mix_run(1'b0, 32'hdb135345, 32'h8e4da1bc, "mmc");
  endtask

  task automatic test_misalign();
    logic [7:0] o;
    clear();
    shift(8'h11, o);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, o);
    total += 2;
    if (bus.BytePtrxDO !== 4'd1) begin
      bad++; $display("FAIL srmc_ptr: got %0d want 1", bus.BytePtrxDO);
    end
    if (bus.MixErrxSO !== 1'b0) begin
      bad++; $display("FAIL srmc_err: got %b want 0", bus.MixErrxSO);
    end
    clear();
    for (int k = 0; k < 16; k++) shift(8'(8'ha0 + k), o);
    shift(8'hff, o);
    total++;
    if (bus.ColStartxSO !== 1'b0) begin
      bad++; $display("FAIL mis_colstart: got %b want 0", bus.ColStartxSO);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hff, o);
    total += 3;
    if (o !== 8'ha1) begin
      bad++; $display("FAIL mis_out: got %h want a1", o);
    end
    if (bus.BytePtrxDO !== 4'd2) begin
      bad++; $display("FAIL mis_ptr: got %0d want 2", bus.BytePtrxDO);
    end
    if (bus.MixErrxSO !== 1'b1) begin
      bad++; $display("FAIL mis_err: got %b want 1", bus.MixErrxSO);
    end
    for (int k = 0; k < 2; k++) begin
      shift(8'hff, o);
      total += 2;
      if (o !== 8'(8'ha2 + k)) begin
        bad++; $display("FAIL mis_next[%0d]: got %h want %h", k, o, 8'(8'ha2 + k));
      end
      if (bus.MixErrxSO !== 1'b1) begin
        bad++; $display("FAIL mis_sticky[%0d]: got %b want 1", k, bus.MixErrxSO);
      end
    end
    clear();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, o);
    total += 3;
    if (bus.MixErrxSO !== 1'b0) begin
      bad++; $display("FAIL clr_err: got %b want 0", bus.MixErrxSO);
    end
    if (bus.BytePtrxDO !== 4'd0) begin
      bad++; $display("FAIL clr_ptr: got %0d want 0", bus.BytePtrxDO);
    end
    if (o !== 8'h00) begin
      bad++; $display("FAIL clr_out: got %h want 00", o);
    end
  endtask

  task automatic test_hold();
    logic [7:0] o, e;
    clear();
    for (int k = 0; k < 8; k++) shift(8'(8'h30 + k), o);
    for (int n = 0; n < 5; n++) begin
      cyc(1'b0, 1'(n == 1), 1'b0, 1'(n == 3), 1'b0, 8'($urandom), o);
      total++;
      if (bus.BytePtrxDO !== 4'd8) begin
        bad++; $display("FAIL hold_ptr[%0d]: got %0d want 8", n, bus.BytePtrxDO);
      end
    end
    for (int k = 8; k < 16; k++) shift(8'(8'h30 + k), o);
    for (int k = 0; k < 16; k++) expQ.push_back(8'(8'h30 + k));
    for (int k = 0; k < 16; k++) begin
      shift(8'hff, o);
      e = expQ.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL hold_out[%0d]: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] o;
    clear();
    for (int k = 0; k < 16; k++) shift(8'(8'h51 + k), o);
    shift(8'h00, o);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, o);
    bus.EnxSI = 1'b0;
    bus.MixColumnsxSI = 1'b0;
    #1;
    total += 2;
    if (unmask(bus.StateOutxDO) !== 8'h53) begin
      bad++; $display("FAIL pre_rst_out: got %h want 53", unmask(bus.StateOutxDO));
    end
    if (bus.MixErrxSO !== 1'b1) begin
      bad++; $display("FAIL pre_rst_err: got %b want 1", bus.MixErrxSO);
    end
    #1;
    RstxBI = 1'b0;
    #1;
    total += 4;
    if (bus.StateOutxDO !== '0) begin
      bad++; $display("FAIL arst_out: got %h want 0", bus.StateOutxDO);
    end
    if (bus.BytePtrxDO !== 4'd0) begin
      bad++; $display("FAIL arst_ptr: got %0d want 0", bus.BytePtrxDO);
    end
    if (bus.ColStartxSO !== 1'b1) begin
      bad++; $display("FAIL arst_colstart: got %b want 1", bus.ColStartxSO);
    end
    if (bus.MixErrxSO !== 1'b0) begin
      bad++; $display("FAIL arst_err: got %b want 0", bus.MixErrxSO);
    end
    #3;
    RstxBI = 1'b1;
    @(posedge ClkxCI);
    #1;
  endtask

  initial begin
    test_reset();
    test_shift_rows();
    test_mix_columns();
    test_masked_mix();
    test_misalign();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
